// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int REG_PC = 15;
  localparam int REG_LR = 14;
  localparam int REG_SP = 13;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 32;

  typedef struct packed {
    logic              valid;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational two-grant round-robin picker: grant A is the first valid from ptr,
// grant B the next valid whose address differs from A's.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [PW-1:0]      ptr,
  output logic               a_valid,
  output logic [PW-1:0]      a_idx,
  output logic               b_valid,
  output logic [PW-1:0]      b_idx
);

  logic [AW-1:0] addr_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [AW-1:0] a_addr;
    a_valid = 1'b0;
    a_idx   = '0;
    b_valid = 1'b0;
    b_idx   = '0;
    a_addr  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Scan order wraps modulo NREQ, which need not be a power of two.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (valid[idx]) begin
        if (!a_valid) begin
          a_valid = 1'b1;
          a_idx   = idx;
          a_addr  = addr_arr[idx];
        end else if (!b_valid && addr_arr[idx] != a_addr) begin
          b_valid = 1'b1;
          b_idx   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: NREQ requesters onto two registered regfile write ports.
// Define WB_SCOREBOARD_EN to build the per-register outstanding-write scoreboard.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic              w_en1,
  output logic [AW-1:0]     w_addr1,
  output logic [DW-1:0]     w_data1,
  output logic              w_en2,
  output logic [AW-1:0]     w_addr2,
  output logic [DW-1:0]     w_data2,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic [2**AW-1:0]  reg_busy,
  output logic              sb_err
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AW;

  logic [PW-1:0] ptr_reg, ptr_next;
  logic          a_valid, b_valid;
  logic [PW-1:0] a_idx, b_idx;
  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  logic          w_en1_reg, w_en1_next, w_en2_reg, w_en2_next;
  logic [AW-1:0] w_addr1_reg, w_addr1_next, w_addr2_reg, w_addr2_next;
  logic [DW-1:0] w_data1_reg, w_data1_next, w_data2_reg, w_data2_next;

  rr_pick2 #(.NREQ(NREQ), .AW(AW)) u_pick (
    .valid   (req_valid),
    .addr    (req_addr),
    .ptr     (ptr_reg),
    .a_valid (a_valid),
    .a_idx   (a_idx),
    .b_valid (b_valid),
    .b_idx   (b_idx)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign data_arr[gi]  = req_data[gi*DW +: DW];
    assign req_ready[gi] = (a_valid && a_idx == PW'(gi)) || (b_valid && b_idx == PW'(gi));
  end

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ-1)) ? '0 : idx + 1'b1;
  endfunction

  // B is always later than A in scan order, so it is the last grant when present.
  always_comb begin
    ptr_next = ptr_reg;
    if (b_valid)      ptr_next = wrap_inc(b_idx);
    else if (a_valid) ptr_next = wrap_inc(a_idx);
  end

  always_comb begin
    w_en1_next   = a_valid;
    w_addr1_next = a_valid ? addr_arr[a_idx] : w_addr1_reg;
    w_data1_next = a_valid ? data_arr[a_idx] : w_data1_reg;
    w_en2_next   = b_valid;
    w_addr2_next = b_valid ? addr_arr[b_idx] : w_addr2_reg;
    w_data2_next = b_valid ? data_arr[b_idx] : w_data2_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg     <= '0;
      w_en1_reg   <= 1'b0;
      w_addr1_reg <= '0;
      w_data1_reg <= '0;
      w_en2_reg   <= 1'b0;
      w_addr2_reg <= '0;
      w_data2_reg <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      w_en1_reg   <= w_en1_next;
      w_addr1_reg <= w_addr1_next;
      w_data1_reg <= w_data1_next;
      w_en2_reg   <= w_en2_next;
      w_addr2_reg <= w_addr2_next;
      w_data2_reg <= w_data2_next;
    end
  end

  assign w_en1   = w_en1_reg;
  assign w_addr1 = w_addr1_reg;
  assign w_data1 = w_data1_reg;
  assign w_en2   = w_en2_reg;
  assign w_addr2 = w_addr2_reg;
  assign w_data2 = w_data2_reg;

`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] err_vec;
  logic            sb_err_reg;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    logic [CNT_W-1:0] cnt_reg;
    logic             inc, dec;
    // The arbiter never writes one register on both ports, so dec is a single event.
    assign inc = rsv_valid && rsv_addr == AW'(gi);
    assign dec = (w_en1_reg && w_addr1_reg == AW'(gi)) || (w_en2_reg && w_addr2_reg == AW'(gi));
    assign err_vec[gi]  = (inc && !dec && cnt_reg == '1) || (dec && !inc && cnt_reg == '0);
    assign reg_busy[gi] = |cnt_reg;

    always_ff @(posedge clk) begin
      if (!rst_n)                                 cnt_reg <= '0;
      else if (inc && !dec && cnt_reg != '1)      cnt_reg <= cnt_reg + 1'b1;
      else if (dec && !inc && cnt_reg != '0)      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        sb_err_reg <= 1'b0;
    else if (|err_vec) sb_err_reg <= 1'b1;
  end

  assign sb_err = sb_err_reg;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign reg_busy   = '0;
  assign sb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table with a write scoreboard,
// plus hand sequences for reset-during-traffic and the optional scoreboard.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NV   = 14;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              w_en1, w_en2;
  logic [AW-1:0]     w_addr1, w_addr2;
  logic [DW-1:0]     w_data1, w_data2;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic [2**AW-1:0]  reg_busy;
  logic              sb_err;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .w_en1(w_en1), .w_addr1(w_addr1), .w_data1(w_data1),
    .w_en2(w_en2), .w_addr2(w_addr2), .w_data2(w_data2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .reg_busy(reg_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]         valid;
    logic [NREQ-1:0][AW-1:0] addr;
    logic [NREQ-1:0][DW-1:0] data;
    logic [NREQ-1:0]         exp_ready;
    logic                    e1;
    logic [AW-1:0]           a1;
    logic [DW-1:0]           d1;
    logic                    e2;
    logic [AW-1:0]           a2;
    logic [DW-1:0]           d2;
  } vec_t;

  typedef struct packed {
    logic          e1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
  } exp_t;

  vec_t tbl [NV];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] rdy,
                              input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic e2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    vec_t t;
    t = '0;
    t.valid = v; t.exp_ready = rdy;
    t.e1 = e1; t.a1 = a1; t.d1 = d1;
    t.e2 = e2; t.a2 = a2; t.d2 = d2;
    return t;
  endfunction

  task automatic rq(input int v, input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tbl[v].addr[r] = a;
    tbl[v].data[r] = d;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic drive_one(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_idle();
    req_valid[r]          = 1'b1;
    req_addr[r*AW +: AW]  = a;
    req_data[r*DW +: DW]  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    exp_t          e, got;
    logic [AW-1:0] h_a1, h_a2;
    logic [DW-1:0] h_d1, h_d2;

    // Pointer starts at 0 after reset; each vector's expectation follows from the previous grants.
    tbl[0]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b1010, 4'b0010, 1, 7, 32'h11, 0, 0, 0);
    rq(1, 1, 7, 32'h11); rq(1, 3, 7, 32'h33);
    tbl[2]  = mk(4'b1000, 4'b1000, 1, 7, 32'h33, 0, 0, 0);
    rq(2, 3, 7, 32'h33);
    tbl[3]  = mk(4'b0101, 4'b0101, 1, 3, 32'hAAAA0003, 1, 5, 32'h5);
    rq(3, 0, 3, 32'hAAAA0003); rq(3, 2, 5, 32'h5);
    tbl[4]  = mk(4'b1000, 4'b1000, 1, 12, 32'hC, 0, 0, 0);
    rq(4, 3, 12, 32'hC);
    for (int i = 5; i <= 7; i++) begin
      if (i == 6) tbl[i] = mk(4'b1111, 4'b1100, 1, 4, 32'h400, 1, 8, 32'h800);
      else        tbl[i] = mk(4'b1111, 4'b0011, 1, 1, 32'h100, 1, 2, 32'h200);
      rq(i, 0, 1, 32'h100); rq(i, 1, 2, 32'h200); rq(i, 2, 4, 32'h400); rq(i, 3, 8, 32'h800);
    end
    tbl[8]  = mk(4'b0101, 4'b0101, 1, 10, 32'hAA, 1, 6, 32'h66);
    rq(8, 0, 6, 32'h66); rq(8, 2, 10, 32'hAA);
    tbl[9]  = mk(4'b1110, 4'b0010, 1, 4, 32'h41, 0, 0, 0);
    rq(9, 1, 4, 32'h41); rq(9, 2, 4, 32'h42); rq(9, 3, 4, 32'h43);
    tbl[10] = mk(4'b1100, 4'b0100, 1, 4, 32'h42, 0, 0, 0);
    rq(10, 2, 4, 32'h42); rq(10, 3, 4, 32'h43);
    tbl[11] = mk(4'b1000, 4'b1000, 1, 4, 32'h43, 0, 0, 0);
    rq(11, 3, 4, 32'h43);
    tbl[12] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(4'b0111, 4'b0101, 1, 2, 32'h20, 1, 9, 32'h29);
    rq(13, 0, 2, 32'h20); rq(13, 1, 2, 32'h21); rq(13, 2, 9, 32'h29);

    // Reset then idle
    rst_n = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
    drive_idle();
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_ready", req_ready, '0);
    end
    chk("rst_w_en1", w_en1, 1'b0);
    chk("rst_w_en2", w_en2, 1'b0);
    chk("rst_w_addr1", w_addr1, '0);
    chk("rst_w_data1", w_data1, '0);
    chk("rst_reg_busy", reg_busy, '0);
    chk("rst_sb_err", sb_err, 1'b0);
    rst_n = 1'b1;
    h_a1 = '0; h_d1 = '0; h_a2 = '0; h_d2 = '0;

    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].valid;
      req_addr  = tbl[i].addr;
      req_data  = tbl[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, tbl[i].exp_ready);
      if (tbl[i].e1) begin h_a1 = tbl[i].a1; h_d1 = tbl[i].d1; end
      if (tbl[i].e2) begin h_a2 = tbl[i].a2; h_d2 = tbl[i].d2; end
      e = '{e1: tbl[i].e1, a1: h_a1, d1: h_d1, e2: tbl[i].e2, a2: h_a2, d2: h_d2};
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{e1: w_en1, a1: w_addr1, d1: w_data1, e2: w_en2, a2: w_addr2, d2: w_data2};
      $display("vec %0d valid=%b ready=%b p1=%b/%0h/%0h p2=%b/%0h/%0h", i, tbl[i].valid,
               tbl[i].exp_ready, w_en1, w_addr1, w_data1, w_en2, w_addr2, w_data2);
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue", i), 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_w_en1", i), got.e1, e.e1);
        chk($sformatf("v%0d_w_addr1", i), got.a1, e.a1);
        chk($sformatf("v%0d_w_data1", i), got.d1, e.d1);
        chk($sformatf("v%0d_w_en2", i), got.e2, e.e2);
        chk($sformatf("v%0d_w_addr2", i), got.a2, e.a2);
        chk($sformatf("v%0d_w_data2", i), got.d2, e.d2);
      end
    end

    // Reset mid-operation: pointer is 3, req1 gets accepted and moves it to 2.
    drive_one(1, 5, 32'h55);
    #1;
    chk("mid_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    chk("mid_w_en1", w_en1, 1'b1);
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("reset mid-op w_en1=%b w_en2=%b", w_en1, w_en2);
    chk("mid_rst_w_en1", w_en1, 1'b0);
    chk("mid_rst_w_en2", w_en2, 1'b0);
    chk("mid_rst_w_addr1", w_addr1, '0);
    chk("mid_rst_busy", reg_busy, '0);
    rst_n = 1'b1;
    // Same-address pair: the pointer alone decides who wins.
    req_valid = 4'b0110;
    req_addr  = {4'd0, 4'd7, 4'd7, 4'd0};
    req_data  = {32'h0, 32'h72, 32'h71, 32'h0};
    #1;
    chk("post_rst_ptr_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    chk("post_rst_w_addr1", w_addr1, 4'd7);
    chk("post_rst_w_data1", w_data1, 32'h71);
    drive_one(2, 7, 32'h72);
    #1;
    chk("post_rst_req2_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("post_rst_req2_data", w_data1, 32'h72);
    chk("post_rst_req2_w_en2", w_en2, 1'b0);
    drive_idle();

    // Scoreboard: two reservations, two commits, then an extra commit underflows.
    rsv_valid = 1'b1; rsv_addr = 4'd9;
    @(posedge clk); @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("sb_busy_rsv", reg_busy, SB ? 16'h0200 : 16'h0000);
    drive_one(0, 9, 32'h91);
    @(posedge clk); #1;
    drive_one(0, 9, 32'h92);
    @(posedge clk); #1;
    drive_idle();
    chk("sb_busy_one_left", reg_busy, SB ? 16'h0200 : 16'h0000);
    chk("sb_second_w_en", w_en1, 1'b1);
    @(posedge clk); #1;
    $display("scoreboard after two commits busy=%h err=%b", reg_busy, sb_err);
    chk("sb_busy_clear", reg_busy, 16'h0000);
    chk("sb_err_clean", sb_err, 1'b0);
    drive_one(0, 9, 32'h93);
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    $display("scoreboard after extra commit err=%b", sb_err);
    chk("sb_err_underflow", sb_err, SB);
    @(posedge clk); #1;
    chk("sb_err_sticky", sb_err, SB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
